// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer: FSM states,
// the zero-register index and the hazard control bundle driven to the stage registers.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [4:0] ZERO_REG    = 5'd31;
    localparam int         STALL_CNT_W = 2;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_flush;
    } hz_ctrl_t;

    // Bundle that keeps every stage register empty (used while in reset).
    localparam hz_ctrl_t HZ_CTRL_NOP = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
                                         idex_bubble: 1'b1, exmem_flush: 1'b1};
    localparam hz_ctrl_t HZ_CTRL_RUN = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, exmem_flush: 1'b0};

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle of pipeline-observation inputs and hazard-control outputs of the sequencer.
interface hazard_sequencer_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rn;
    logic             id_rn_used;
    logic [REG_W-1:0] id_rm;
    logic             id_rm_used;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [REG_W-1:0] ex_rd;
    logic             mem_br_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_events;
    logic [CNT_W-1:0] flush_events;

    modport master (
        input  id_rn, id_rn_used, id_rm, id_rm_used,
        input  ex_mem_read, ex_reg_write, ex_rd, mem_br_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush,
        output state_o, stall_events, flush_events
    );

    modport slave (
        output id_rn, id_rn_used, id_rm, id_rm_used,
        output ex_mem_read, ex_reg_write, ex_rd, mem_br_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush,
        input  state_o, stall_events, flush_events
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the instruction in ID and a load in EX.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rn_i,
    input  logic             id_rn_used_i,
    input  logic [REG_W-1:0] id_rm_i,
    input  logic             id_rm_used_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [REG_W-1:0] ex_rd_i,
    output logic             lu_o
);
    logic rd_live_s;
    logic rn_hit_s;
    logic rm_hit_s;

    // XZR reads as zero, so a load targeting it never produces a value to wait for.
    assign rd_live_s = ex_mem_read_i & ex_reg_write_i & (ex_rd_i != REG_W'(ZERO_REG));
    assign rn_hit_s  = id_rn_used_i & (id_rn_i == ex_rd_i);
    assign rm_hit_s  = id_rm_used_i & (id_rm_i == ex_rd_i);
    assign lu_o      = rd_live_s & (rn_hit_s | rm_hit_s);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stalls, taken-branch squash, reset hold
// and saturating performance counters.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_sequencer_if.master hz
);
    localparam logic                   MULTI_STALL = (STALL_CYCLES > 1);
    localparam logic [STALL_CNT_W-1:0] CNT_LOAD    = STALL_CNT_W'(STALL_CYCLES - 1);

    hz_state_e              state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]       stall_ev_q, stall_ev_d;
    logic [CNT_W-1:0]       flush_ev_q, flush_ev_d;
    hz_ctrl_t               ctrl_fsm_s;
    hz_ctrl_t               ctrl_s;
    logic                   lu_s;
    logic                   stall_inc_s;
    logic                   flush_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .id_rn_i        (hz.id_rn),
        .id_rn_used_i   (hz.id_rn_used),
        .id_rm_i        (hz.id_rm),
        .id_rm_used_i   (hz.id_rm_used),
        .ex_mem_read_i  (hz.ex_mem_read),
        .ex_reg_write_i (hz.ex_reg_write),
        .ex_rd_i        (hz.ex_rd),
        .lu_o           (lu_s)
    );

    // Next-state, stall countdown and control outputs of the hazard FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_fsm_s  = HZ_CTRL_RUN;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.mem_br_taken) begin
                    ctrl_fsm_s.ifid_flush  = 1'b1;
                    ctrl_fsm_s.idex_bubble = 1'b1;
                    ctrl_fsm_s.exmem_flush = 1'b1;
                    flush_inc_s            = 1'b1;
                    state_d                = ST_FLUSH;
                end else if (lu_s) begin
                    ctrl_fsm_s.pc_we       = 1'b0;
                    ctrl_fsm_s.ifid_we     = 1'b0;
                    ctrl_fsm_s.idex_bubble = 1'b1;
                    stall_inc_s            = 1'b1;
                    if (MULTI_STALL) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                // A taken branch makes the stalled instruction dead, so abort the stall.
                if (hz.mem_br_taken) begin
                    ctrl_fsm_s.ifid_flush  = 1'b1;
                    ctrl_fsm_s.idex_bubble = 1'b1;
                    ctrl_fsm_s.exmem_flush = 1'b1;
                    flush_inc_s            = 1'b1;
                    cnt_d                  = {STALL_CNT_W{1'b0}};
                    state_d                = ST_FLUSH;
                end else begin
                    ctrl_fsm_s.pc_we       = 1'b0;
                    ctrl_fsm_s.ifid_we     = 1'b0;
                    ctrl_fsm_s.idex_bubble = 1'b1;
                    if (cnt_q <= STALL_CNT_W'(1)) begin
                        cnt_d   = {STALL_CNT_W{1'b0}};
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - STALL_CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                cnt_d   = {STALL_CNT_W{1'b0}};
                state_d = ST_RUN;
            end
            default: begin
                cnt_d   = {STALL_CNT_W{1'b0}};
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating event counter next values.
    always_comb begin
        stall_ev_d = stall_inc_s ? sat_inc(stall_ev_q) : stall_ev_q;
        flush_ev_d = flush_inc_s ? sat_inc(flush_ev_q) : flush_ev_q;
    end

    // State, stall countdown and counters; reset abandons everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= {STALL_CNT_W{1'b0}};
            stall_ev_q <= {CNT_W{1'b0}};
            flush_ev_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stall_ev_q <= stall_ev_d;
            flush_ev_q <= flush_ev_d;
        end
    end

    // Outputs are combinational so the stage registers act in the same cycle.
    assign ctrl_s          = reset ? ctrl_fsm_s : HZ_CTRL_NOP;
    assign hz.pc_we        = ctrl_s.pc_we;
    assign hz.ifid_we      = ctrl_s.ifid_we;
    assign hz.ifid_flush   = ctrl_s.ifid_flush;
    assign hz.idex_bubble  = ctrl_s.idex_bubble;
    assign hz.exmem_flush  = ctrl_s.exmem_flush;
    assign hz.state_o      = state_q;
    assign hz.stall_events = stall_ev_q;
    assign hz.flush_events = flush_ev_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer across several parameterisations.
module tb_hazard_sequencer;
    logic       clk;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_rn_used, id_rm_used, ex_mem_read, ex_reg_write, mem_br_taken;
    int         checks;
    int         failures;

    hazard_sequencer_if #(.REG_W(5), .CNT_W(16)) if1 ();
    hazard_sequencer_if #(.REG_W(5), .CNT_W(16)) if3 ();
    hazard_sequencer_if #(.REG_W(5), .CNT_W(16)) if4 ();
    hazard_sequencer_if #(.REG_W(5), .CNT_W(4))  ifs ();

    hazard_sequencer #(.REG_W(5), .STALL_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .hz(if1));
    hazard_sequencer #(.REG_W(5), .STALL_CYCLES(3), .CNT_W(16)) dut3 (.clk(clk), .reset(reset), .hz(if3));
    hazard_sequencer #(.REG_W(5), .STALL_CYCLES(4), .CNT_W(16)) dut4 (.clk(clk), .reset(reset), .hz(if4));
    hazard_sequencer #(.REG_W(5), .STALL_CYCLES(1), .CNT_W(4))  duts (.clk(clk), .reset(reset), .hz(ifs));

    assign {if1.id_rn, if3.id_rn, if4.id_rn, ifs.id_rn} = {4{id_rn}};
    assign {if1.id_rm, if3.id_rm, if4.id_rm, ifs.id_rm} = {4{id_rm}};
    assign {if1.ex_rd, if3.ex_rd, if4.ex_rd, ifs.ex_rd} = {4{ex_rd}};
    assign {if1.id_rn_used, if3.id_rn_used, if4.id_rn_used, ifs.id_rn_used} = {4{id_rn_used}};
    assign {if1.id_rm_used, if3.id_rm_used, if4.id_rm_used, ifs.id_rm_used} = {4{id_rm_used}};
    assign {if1.ex_mem_read, if3.ex_mem_read, if4.ex_mem_read, ifs.ex_mem_read} = {4{ex_mem_read}};
    assign {if1.ex_reg_write, if3.ex_reg_write, if4.ex_reg_write, ifs.ex_reg_write} = {4{ex_reg_write}};
    assign {if1.mem_br_taken, if3.mem_br_taken, if4.mem_br_taken, ifs.mem_br_taken} = {4{mem_br_taken}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rn, input logic rn_u, input logic [4:0] rm, input logic rm_u,
                          input logic mr, input logic rw, input logic [4:0] rd, input logic br);
        id_rn = rn; id_rn_used = rn_u; id_rm = rm; id_rm_used = rm_u;
        ex_mem_read = mr; ex_reg_write = rw; ex_rd = rd; mem_br_taken = br;
    endtask

    task automatic set_idle();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic br);
        set_in(rd, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, rd, br);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        set_idle();
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        tick();
        tick();
        checks++; if (if1.pc_we !== 1'b0) begin failures++; $display("FAIL rst_pc_we got=%0b exp=0", if1.pc_we); end
        checks++; if (if1.ifid_we !== 1'b0) begin failures++; $display("FAIL rst_ifid_we got=%0b exp=0", if1.ifid_we); end
        checks++; if (if1.ifid_flush !== 1'b1) begin failures++; $display("FAIL rst_ifid_flush got=%0b exp=1", if1.ifid_flush); end
        checks++; if (if1.idex_bubble !== 1'b1) begin failures++; $display("FAIL rst_idex_bubble got=%0b exp=1", if1.idex_bubble); end
        checks++; if (if1.exmem_flush !== 1'b1) begin failures++; $display("FAIL rst_exmem_flush got=%0b exp=1", if1.exmem_flush); end
        checks++; if (if1.state_o !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", if1.state_o); end
        checks++; if (if1.stall_events !== 16'd0) begin failures++; $display("FAIL rst_stall_ev got=%0d exp=0", if1.stall_events); end
        checks++; if (if1.flush_events !== 16'd0) begin failures++; $display("FAIL rst_flush_ev got=%0d exp=0", if1.flush_events); end
        reset = 1'b1;
        #1;
        checks++; if ({if1.pc_we, if1.ifid_we, if1.ifid_flush, if1.idex_bubble, if1.exmem_flush} !== 5'b11000) begin
            failures++; $display("FAIL rel_ctrl got=%05b exp=11000", {if1.pc_we, if1.ifid_we, if1.ifid_flush, if1.idex_bubble, if1.exmem_flush}); end
        tick();
        checks++; if ({if1.pc_we, if1.ifid_we, if1.state_o} !== 4'b1100) begin
            failures++; $display("FAIL rel_next got=%04b exp=1100", {if1.pc_we, if1.ifid_we, if1.state_o}); end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_lu(5'd3, 1'b0);
        #1;
        checks++; if ({if1.pc_we, if1.ifid_we, if1.idex_bubble, if1.ifid_flush, if1.exmem_flush} !== 5'b00100) begin
            failures++; $display("FAIL lu_ctrl got=%05b exp=00100", {if1.pc_we, if1.ifid_we, if1.idex_bubble, if1.ifid_flush, if1.exmem_flush}); end
        tick();
        set_lu(5'd31, 1'b0);
        #1;
        checks++; if (if1.stall_events !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", if1.stall_events); end
        checks++; if (if1.state_o !== 2'd0) begin failures++; $display("FAIL lu_state1 got=%0d exp=0", if1.state_o); end
        checks++; if ({if1.pc_we, if1.idex_bubble} !== 2'b10) begin failures++; $display("FAIL lu_xzr got=%02b exp=10", {if1.pc_we, if1.idex_bubble}); end
        tick();
        set_in(5'd0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        #1;
        checks++; if ({if1.pc_we, if1.idex_bubble} !== 2'b01) begin failures++; $display("FAIL lu_rm got=%02b exp=01", {if1.pc_we, if1.idex_bubble}); end
        tick();
        set_in(5'd0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
        #1;
        checks++; if ({if1.pc_we, if1.idex_bubble} !== 2'b10) begin failures++; $display("FAIL lu_rm_unused got=%02b exp=10", {if1.pc_we, if1.idex_bubble}); end
        checks++; if (if1.stall_events !== 16'd2) begin failures++; $display("FAIL lu_count2 got=%0d exp=2", if1.stall_events); end
        tick();
        set_in(5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
        #1;
        checks++; if ({if1.pc_we, if1.idex_bubble} !== 2'b10) begin failures++; $display("FAIL lu_no_write got=%02b exp=10", {if1.pc_we, if1.idex_bubble}); end
        tick();
        set_idle();
        #1;
        checks++; if (if1.stall_events !== 16'd2) begin failures++; $display("FAIL lu_count_end got=%0d exp=2", if1.stall_events); end
    endtask

    task automatic test_multi_cycle();
        apply_reset();
        set_lu(5'd3, 1'b0);
        #1;
        checks++; if ({if3.state_o, if3.pc_we, if3.idex_bubble} !== 4'b0001) begin
            failures++; $display("FAIL mc_c1 got=%04b exp=0001", {if3.state_o, if3.pc_we, if3.idex_bubble}); end
        tick();
        checks++; if ({if3.state_o, if3.pc_we, if3.ifid_we, if3.idex_bubble} !== 5'b01001) begin
            failures++; $display("FAIL mc_c2 got=%05b exp=01001", {if3.state_o, if3.pc_we, if3.ifid_we, if3.idex_bubble}); end
        tick();
        set_idle();
        #1;
        checks++; if ({if3.state_o, if3.pc_we, if3.idex_bubble} !== 4'b0101) begin
            failures++; $display("FAIL mc_c3 got=%04b exp=0101", {if3.state_o, if3.pc_we, if3.idex_bubble}); end
        tick();
        checks++; if ({if3.state_o, if3.pc_we, if3.idex_bubble} !== 4'b0010) begin
            failures++; $display("FAIL mc_c4 got=%04b exp=0010", {if3.state_o, if3.pc_we, if3.idex_bubble}); end
        checks++; if (if3.stall_events !== 16'd1) begin failures++; $display("FAIL mc_count got=%0d exp=1", if3.stall_events); end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        set_lu(5'd3, 1'b1);
        #1;
        checks++; if ({if1.pc_we, if1.ifid_flush, if1.idex_bubble, if1.exmem_flush, if1.state_o} !== 6'b111100) begin
            failures++; $display("FAIL bp_ctrl got=%06b exp=111100", {if1.pc_we, if1.ifid_flush, if1.idex_bubble, if1.exmem_flush, if1.state_o}); end
        tick();
        #1;
        checks++; if ({if1.state_o, if1.pc_we, if1.ifid_we, if1.ifid_flush, if1.idex_bubble, if1.exmem_flush} !== 7'b1011000) begin
            failures++; $display("FAIL bp_flush got=%07b exp=1011000", {if1.state_o, if1.pc_we, if1.ifid_we, if1.ifid_flush, if1.idex_bubble, if1.exmem_flush}); end
        tick();
        set_idle();
        #1;
        checks++; if (if1.state_o !== 2'd0) begin failures++; $display("FAIL bp_state got=%0d exp=0", if1.state_o); end
        checks++; if (if1.flush_events !== 16'd1) begin failures++; $display("FAIL bp_flush_ev got=%0d exp=1", if1.flush_events); end
        checks++; if (if1.stall_events !== 16'd0) begin failures++; $display("FAIL bp_stall_ev got=%0d exp=0", if1.stall_events); end
    endtask

    task automatic test_branch_mid_stall();
        apply_reset();
        set_lu(5'd5, 1'b0);
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if ({if4.state_o, if4.pc_we, if4.ifid_flush, if4.idex_bubble, if4.exmem_flush} !== 6'b011111) begin
            failures++; $display("FAIL bms_ctrl got=%06b exp=011111", {if4.state_o, if4.pc_we, if4.ifid_flush, if4.idex_bubble, if4.exmem_flush}); end
        tick();
        set_idle();
        #1;
        checks++; if ({if4.state_o, if4.pc_we, if4.exmem_flush} !== 4'b1010) begin
            failures++; $display("FAIL bms_flush got=%04b exp=1010", {if4.state_o, if4.pc_we, if4.exmem_flush}); end
        tick();
        checks++; if (if4.state_o !== 2'd0) begin failures++; $display("FAIL bms_run got=%0d exp=0", if4.state_o); end
        checks++; if ({if4.stall_events, if4.flush_events} !== {16'd1, 16'd1}) begin
            failures++; $display("FAIL bms_counts got=%0d/%0d exp=1/1", if4.stall_events, if4.flush_events); end
        apply_reset();
        set_lu(5'd5, 1'b0);
        tick();
        checks++; if (if4.state_o !== 2'd1) begin failures++; $display("FAIL rms_in_stall got=%0d exp=1", if4.state_o); end
        reset = 1'b0;
        #1;
        checks++; if ({if4.state_o, if4.pc_we, if4.exmem_flush} !== 4'b0001) begin
            failures++; $display("FAIL rms_async got=%04b exp=0001", {if4.state_o, if4.pc_we, if4.exmem_flush}); end
        checks++; if (if4.stall_events !== 16'd0) begin failures++; $display("FAIL rms_count got=%0d exp=0", if4.stall_events); end
        tick();
        reset = 1'b1;
        set_idle();
        #1;
        checks++; if ({if4.state_o, if4.pc_we, if4.idex_bubble} !== 4'b0010) begin
            failures++; $display("FAIL rms_after got=%04b exp=0010", {if4.state_o, if4.pc_we, if4.idex_bubble}); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            set_lu(5'd9, 1'b0);
            tick();
            set_idle();
            tick();
            if (i == 14) begin
                checks++; if (ifs.stall_events !== 4'd15) begin failures++; $display("FAIL sat_at15 got=%0d exp=15", ifs.stall_events); end
            end
        end
        checks++; if (ifs.stall_events !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", ifs.stall_events); end
        checks++; if (if1.stall_events !== 16'd20) begin failures++; $display("FAIL sat_wide got=%0d exp=20", if1.stall_events); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        set_idle();
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_branch_priority();
        test_branch_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
